// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants and types for the synchronous FIFO controller slice.
// Default depth/threshold values and the pointer-width helper live here.
package sync_fifo_ctrl_pkg;

  localparam int ADDRSIZE_DEF  = 4;
  localparam int AFULL_TH_DEF  = 14;
  localparam int AEMPTY_TH_DEF = 2;

  typedef struct packed {
    logic ovf;
    logic udf;
  } err_t;

  // Pointers carry one extra lap bit above the RAM address.
  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Request/status bundle between producer/consumer logic and the FIFO controller.
// The RAM-facing address/enable signals ride along so the parent can wire fifomem.
interface sync_fifo_ctrl_if
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF
);

  logic                push;
  logic                pop;
  logic                flush;
  logic                clr_err;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE-1:0] raddr;
  logic                wclken;
  logic                wfull;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output push, pop, flush, clr_err,
    input  waddr, raddr, wclken, wfull, full, empty,
    input  almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clr_err,
    output waddr, raddr, wclken, wfull, full, empty,
    output almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifomem.sv
// Dual-port FIFO RAM: registered write on wclk, combinational read at raddr.
module fifomem #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 4
) (
  output logic [DATASIZE-1:0] rdata,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [ADDRSIZE-1:0] raddr,
  input  logic                wclken,
  input  logic                wfull,
  input  logic                wclk
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_r [DEPTH];

  // Storage write; contents are not reset.
  always_ff @(posedge wclk) begin
    if (wclken && !wfull) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_ctrl_ptr.sv
// Binary FIFO pointer with lap bit: async reset, synchronous clear, increment enable.
module fifo_ptr #(
  parameter int PTRW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [PTRW-1:0] ptr
);

  // Pointer register; wraps naturally at 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTRW'(1'b1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller driving one fifomem instance.
// Flags and count derive only from the registered pointers; requests are gated by pre-edge flags.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ADDRSIZE  = ADDRSIZE_DEF,
  parameter int AFULL_TH  = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_ctrl_if.slave bus
);

  localparam int PTRW = ptr_width(ADDRSIZE);

  logic [PTRW-1:0] wptr_s;
  logic [PTRW-1:0] rptr_s;
  logic [PTRW-1:0] count_s;
  logic            full_s;
  logic            empty_s;
  logic            do_wr_s;
  logic            do_rd_s;
  err_t            err_r;

  fifo_ptr #(.PTRW(PTRW)) u_wptr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.flush),
    .inc  (do_wr_s),
    .ptr  (wptr_s)
  );

  fifo_ptr #(.PTRW(PTRW)) u_rptr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.flush),
    .inc  (do_rd_s),
    .ptr  (rptr_s)
  );

  // Occupancy flags from pointers; flush suppresses both transfers.
  always_comb begin
    empty_s = (wptr_s == rptr_s);
    full_s  = (wptr_s[PTRW-1] != rptr_s[PTRW-1]) &&
              (wptr_s[ADDRSIZE-1:0] == rptr_s[ADDRSIZE-1:0]);
    count_s = wptr_s - rptr_s;
    do_wr_s = bus.push && !full_s && !bus.flush;
    do_rd_s = bus.pop && !empty_s && !bus.flush;
  end

  // Sticky error flags; a new error outranks a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= '0;
    end else begin
      if (bus.push && full_s) begin
        err_r.ovf <= 1'b1;
      end else if (bus.clr_err) begin
        err_r.ovf <= 1'b0;
      end else begin
        err_r.ovf <= err_r.ovf;
      end
      if (bus.pop && empty_s) begin
        err_r.udf <= 1'b1;
      end else if (bus.clr_err) begin
        err_r.udf <= 1'b0;
      end else begin
        err_r.udf <= err_r.udf;
      end
    end
  end

  assign bus.waddr        = wptr_s[ADDRSIZE-1:0];
  assign bus.raddr        = rptr_s[ADDRSIZE-1:0];
  assign bus.wclken       = do_wr_s;
  assign bus.wfull        = full_s;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_s >= PTRW'(AFULL_TH));
  assign bus.almost_empty = (count_s <= PTRW'(AEMPTY_TH));
  assign bus.count        = count_s;
  assign bus.overflow     = err_r.ovf;
  assign bus.underflow    = err_r.udf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl + fifomem: directed scenarios then random traffic,
// compared against a queue-based FIFO model.
module tb_sync_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] wdata;
  logic [31:0] rdata;

  sync_fifo_ctrl_if #(.ADDRSIZE(AW)) ff_if ();

  sync_fifo_ctrl #(.ADDRSIZE(AW), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ff_if)
  );

  fifomem #(.DATASIZE(32), .ADDRSIZE(AW)) u_mem (
    .rdata (rdata),
    .wdata (wdata),
    .waddr (ff_if.waddr),
    .raddr (ff_if.raddr),
    .wclken(ff_if.wclken),
    .wfull (ff_if.wfull),
    .wclk  (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] q[$];
  int          n_wr;
  int          n_rd;
  bit          m_ovf;
  bit          m_udf;
  int          checks;
  int          errors;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    n_wr  = 0;
    n_rd  = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_state();
    check_val("count", 32'(ff_if.count), 32'(q.size()));
    check_val("empty", 32'(ff_if.empty), 32'(q.size() == 0));
    check_val("full", 32'(ff_if.full), 32'(q.size() == DEPTH));
    check_val("wfull", 32'(ff_if.wfull), 32'(q.size() == DEPTH));
    check_val("almost_full", 32'(ff_if.almost_full), 32'(q.size() >= 14));
    check_val("almost_empty", 32'(ff_if.almost_empty), 32'(q.size() <= 2));
    check_val("overflow", 32'(ff_if.overflow), 32'(m_ovf));
    check_val("underflow", 32'(ff_if.underflow), 32'(m_udf));
    check_val("waddr", 32'(ff_if.waddr), 32'(n_wr % DEPTH));
    check_val("raddr", 32'(ff_if.raddr), 32'(n_rd % DEPTH));
  endtask

  // One clock of traffic: drive, check pre-edge outputs, advance the model, check post-edge.
  task automatic step(input bit pu, input bit po, input bit fl, input bit ce, input logic [31:0] wd);
    bit mfull;
    bit mempty;
    bit dwr;
    bit drd;
    mfull  = (q.size() == DEPTH);
    mempty = (q.size() == 0);
    dwr    = pu && !mfull && !fl;
    drd    = po && !mempty && !fl;
    ff_if.push    = pu;
    ff_if.pop     = po;
    ff_if.flush   = fl;
    ff_if.clr_err = ce;
    wdata         = wd;
    #1;
    check_val("wclken", 32'(ff_if.wclken), 32'(dwr));
    if (!mempty) check_val("rdata_head", rdata, q[0]);
    @(posedge clk);
    #1;
    if (pu && mfull) m_ovf = 1'b1;
    else if (ce) m_ovf = 1'b0;
    if (po && mempty) m_udf = 1'b1;
    else if (ce) m_udf = 1'b0;
    if (fl) begin
      q.delete();
      n_wr = 0;
      n_rd = 0;
    end else begin
      if (drd) begin
        void'(q.pop_front());
        n_rd++;
      end
      if (dwr) begin
        q.push_back(wd);
        n_wr++;
      end
    end
    check_state();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    ff_if.push    = 1'b0;
    ff_if.pop     = 1'b0;
    ff_if.flush   = 1'b0;
    ff_if.clr_err = 1'b0;
    wdata         = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    rst_n = 1'b1;

    // Underflow, then reset mid-stream with 5 entries held.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'hA0 + 32'(i));
    ff_if.push = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill to full, then one push too many.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);
    // Push+pop at full: pop only.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hBEEF);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Streaming pairs across the pointer wrap.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(i));
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Clear errors, then push+pop on empty: push only, underflow.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h300);

    // Flush at count 9 with a push pending.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h400 + 32'(i));
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h5555);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Clear coinciding with overflow, then clear alone.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h600 + 32'(i));
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h777);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);

    // Random traffic: push-biased half, then pop-biased half.
    for (int i = 0; i < 600; i++) begin
      int pw;
      int pr;
      pw = (i < 300) ? 70 : 40;
      pr = (i < 300) ? 40 : 70;
      step(32'($urandom_range(0, 99)) < 32'(pw),
           32'($urandom_range(0, 99)) < 32'(pr),
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 4,
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
